// File: rtl/mode_timer_ctrl.sv
// Mode/timer controller for an appliance-style panel.
// - Button edges move between the standby, three power levels and the clean cycle.
// - A one-second prescaler drives the elapsed counter (left_time).
// - The same prescaler drives the remaining-time counter (right_time) of timed modes.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_OFF      | power stage off, all outputs idle
// ST_STANDBY  | powered, no mode selected
// ST_LEVEL1   | level 1 running, untimed
// ST_LEVEL2   | level 2 running, untimed
// ST_LEVEL3   | level 3 running, times out back to level 2 (once per power-up)
// ST_CLEAN    | clean cycle running, times out to standby with clean_done
module mode_timer_ctrl #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int LEVEL3_SEC    = 60,
    parameter int CLEAN_SEC     = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_status,
    input  logic       menu_stable,
    input  logic       left_stable,
    input  logic       right_stable,
    output logic [7:0] selection,
    output logic [7:0] left_time,
    output logic [7:0] right_time,
    output logic       clean_done
);

    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0] LEVEL3_LOAD = 8'(LEVEL3_SEC);
    localparam logic [7:0] CLEAN_LOAD  = 8'(CLEAN_SEC);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_STANDBY,
        ST_LEVEL1,
        ST_LEVEL2,
        ST_LEVEL3,
        ST_CLEAN
    } state_t;

    state_t               state_q, state_d;
    logic                 menu_prev_q, left_prev_q, right_prev_q;
    logic                 level3_used_q, level3_used_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [7:0]           selection_q, selection_d;
    logic [7:0]           left_time_q, left_time_d;
    logic [7:0]           right_time_q, right_time_d;
    logic                 clean_done_q, clean_done_d;

    logic                 menu_edge, left_edge, right_edge;
    logic                 tick;
    logic                 timed_mode;
    logic                 expired;
    logic                 clean_timeout;
    logic                 state_change;

    assign menu_edge  = menu_stable  & ~menu_prev_q;
    assign left_edge  = left_stable  & ~left_prev_q;
    assign right_edge = right_stable & ~right_prev_q;
    assign tick       = (presc_q == PRESC_LAST);
    assign timed_mode = (state_q == ST_LEVEL3) || (state_q == ST_CLEAN);
    assign expired    = tick && timed_mode && (right_time_q == 8'd1);

    // State, timers, button history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_OFF;
            menu_prev_q   <= 1'b0;
            left_prev_q   <= 1'b0;
            right_prev_q  <= 1'b0;
            level3_used_q <= 1'b0;
            presc_q       <= '0;
            selection_q   <= 8'h00;
            left_time_q   <= 8'd0;
            right_time_q  <= 8'd0;
            clean_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            menu_prev_q   <= menu_stable;
            left_prev_q   <= left_stable;
            right_prev_q  <= right_stable;
            level3_used_q <= level3_used_d;
            presc_q       <= presc_d;
            selection_q   <= selection_d;
            left_time_q   <= left_time_d;
            right_time_q  <= right_time_d;
            clean_done_q  <= clean_done_d;
        end
    end

    // Next-state: power loss first, then the single highest-priority button
    // edge, then timeout. An edge the current state ignores does not stop a timeout.
    always_comb begin
        state_d       = state_q;
        level3_used_d = level3_used_q;
        clean_timeout = 1'b0;
        if (!power_status) begin
            state_d       = ST_OFF;
            level3_used_d = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_STANDBY;
                ST_STANDBY: begin
                    if (menu_edge)       state_d = ST_CLEAN;
                    else if (left_edge)  state_d = ST_STANDBY;
                    else if (right_edge) state_d = ST_LEVEL1;
                end
                ST_LEVEL1: begin
                    if (menu_edge)       state_d = ST_STANDBY;
                    else if (left_edge)  state_d = ST_STANDBY;
                    else if (right_edge) state_d = ST_LEVEL2;
                end
                ST_LEVEL2: begin
                    if (menu_edge)       state_d = ST_STANDBY;
                    else if (left_edge)  state_d = ST_LEVEL1;
                    else if (right_edge && !level3_used_q) state_d = ST_LEVEL3;
                end
                ST_LEVEL3: begin
                    if (menu_edge)       state_d = ST_STANDBY;
                    else if (left_edge)  state_d = ST_LEVEL2;
                    else if (expired)    state_d = ST_LEVEL2;
                end
                ST_CLEAN: begin
                    if (menu_edge) begin
                        state_d = ST_STANDBY;
                    end else if (expired) begin
                        state_d       = ST_STANDBY;
                        clean_timeout = 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
            if (state_d == ST_LEVEL3 && state_q != ST_LEVEL3)
                level3_used_d = 1'b1;
        end
    end

    // Outputs and timers for the coming state; any state change restarts
    // the second prescaler and the elapsed counter.
    always_comb begin
        state_change = (state_d != state_q);
        presc_d      = (state_change || tick) ? '0 : presc_q + 1'b1;
        clean_done_d = clean_timeout;

        case (state_d)
            ST_STANDBY: selection_d = 8'h01;
            ST_LEVEL1:  selection_d = 8'h02;
            ST_LEVEL2:  selection_d = 8'h04;
            ST_LEVEL3:  selection_d = 8'h08;
            ST_CLEAN:   selection_d = 8'h10;
            default:    selection_d = 8'h00;
        endcase

        left_time_d = left_time_q;
        if (state_d == ST_OFF || state_change)
            left_time_d = 8'd0;
        else if (tick && left_time_q != 8'hFF)
            left_time_d = left_time_q + 8'd1;

        right_time_d = right_time_q;
        if (state_d == ST_OFF) begin
            right_time_d = 8'd0;
        end else if (state_change) begin
            if (state_d == ST_LEVEL3)     right_time_d = LEVEL3_LOAD;
            else if (state_d == ST_CLEAN) right_time_d = CLEAN_LOAD;
            else                          right_time_d = 8'd0;
        end else if (tick && timed_mode) begin
            right_time_d = right_time_q - 8'd1;
        end
    end

    assign selection  = selection_q;
    assign left_time  = left_time_q;
    assign right_time = right_time_q;
    assign clean_done = clean_done_q;

endmodule

// File: tb/tb_mode_timer_ctrl.sv
// Directed bench for mode_timer_ctrl with short timers (10-cycle second,
// LEVEL3 = 3 s, CLEAN = 5 s). Expected values are hand-derived.
module tb_mode_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       power_status;
    logic       menu_stable;
    logic       left_stable;
    logic       right_stable;
    logic [7:0] selection;
    logic [7:0] left_time;
    logic [7:0] right_time;
    logic       clean_done;

    int n_checks = 0;
    int n_fail   = 0;

    mode_timer_ctrl #(
        .TICKS_PER_SEC(10),
        .LEVEL3_SEC(3),
        .CLEAN_SEC(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .power_status(power_status),
        .menu_stable(menu_stable),
        .left_stable(left_stable),
        .right_stable(right_stable),
        .selection(selection),
        .left_time(left_time),
        .right_time(right_time),
        .clean_done(clean_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic btns(input logic m, input logic l, input logic r);
        menu_stable  = m;
        left_stable  = l;
        right_stable = r;
    endtask

    // Single right press, then release for one cycle.
    task automatic press_right(input string tag, input logic [7:0] exp_sel);
        btns(1'b0, 1'b0, 1'b1);
        step(1);
        check_eq(tag, selection, exp_sel);
        btns(1'b0, 1'b0, 1'b0);
        step(1);
    endtask

    initial begin
        rst = 1'b1;
        power_status = 1'b0;
        btns(1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #2;
        check_eq("rst_sel", selection, 8'h00);
        check_eq("rst_left", left_time, 8'd0);
        check_eq("rst_right", right_time, 8'd0);
        check_eq("rst_cd", clean_done, 1'b0);
        step(2);
        rst = 1'b1;
        step(2);
        check_eq("off_hold_sel", selection, 8'h00);

        // Power-up to standby and elapsed-seconds counting.
        power_status = 1'b1;
        step(1);
        check_eq("pwr_on_sel", selection, 8'h01);
        check_eq("pwr_on_left", left_time, 8'd0);
        step(25);
        check_eq("sb25_left", left_time, 8'd2);
        check_eq("sb25_right", right_time, 8'd0);

        // Level walk and LEVEL3 timeout.
        press_right("r1_sel", 8'h02);
        press_right("r2_sel", 8'h04);
        btns(1'b0, 1'b0, 1'b1);
        step(1);
        check_eq("r3_sel", selection, 8'h08);
        check_eq("r3_right", right_time, 8'd3);
        btns(1'b0, 1'b0, 1'b0);
        step(1);
        step(8);
        check_eq("l3_9_right", right_time, 8'd3);
        check_eq("l3_9_left", left_time, 8'd0);
        step(1);
        check_eq("l3_10_right", right_time, 8'd2);
        check_eq("l3_10_left", left_time, 8'd1);
        step(20);
        check_eq("l3_to_sel", selection, 8'h04);
        check_eq("l3_to_right", right_time, 8'd0);
        check_eq("l3_to_left", left_time, 8'd0);
        check_eq("l3_to_cd", clean_done, 1'b0);
        press_right("l3_used_sel", 8'h04);

        // Power loss clears level3_used; power loss during LEVEL3.
        power_status = 1'b0;
        step(1);
        check_eq("poff_sel", selection, 8'h00);
        power_status = 1'b1;
        step(1);
        check_eq("pon2_sel", selection, 8'h01);
        press_right("p2r1_sel", 8'h02);
        press_right("p2r2_sel", 8'h04);
        btns(1'b0, 1'b0, 1'b1);
        step(1);
        check_eq("p2r3_sel", selection, 8'h08);
        btns(1'b0, 1'b0, 1'b0);
        step(1);
        step(11);
        check_eq("p2l3_right", right_time, 8'd2);
        check_eq("p2l3_left", left_time, 8'd1);
        power_status = 1'b0;
        step(1);
        check_eq("poff_l3_sel", selection, 8'h00);
        check_eq("poff_l3_left", left_time, 8'd0);
        check_eq("poff_l3_right", right_time, 8'd0);
        power_status = 1'b1;
        step(1);
        check_eq("pon3_sel", selection, 8'h01);
        press_right("p3r1_sel", 8'h02);
        press_right("p3r2_sel", 8'h04);
        press_right("p3r3_sel", 8'h08);
        btns(1'b1, 1'b0, 1'b0);
        step(1);
        check_eq("menu_l3_sel", selection, 8'h01);
        check_eq("menu_l3_right", right_time, 8'd0);
        btns(1'b0, 1'b0, 1'b0);
        step(1);

        // Full CLEAN run with clean_done pulse.
        btns(1'b1, 1'b0, 1'b0);
        step(1);
        check_eq("cl_sel", selection, 8'h10);
        check_eq("cl_right", right_time, 8'd5);
        btns(1'b0, 1'b0, 1'b0);
        step(1);
        step(47);
        check_eq("cl48_sel", selection, 8'h10);
        check_eq("cl48_right", right_time, 8'd1);
        check_eq("cl48_left", left_time, 8'd4);
        check_eq("cl48_cd", clean_done, 1'b0);
        step(1);
        check_eq("cl49_cd", clean_done, 1'b0);
        step(1);
        check_eq("cl50_sel", selection, 8'h01);
        check_eq("cl50_cd", clean_done, 1'b1);
        check_eq("cl50_right", right_time, 8'd0);
        step(1);
        check_eq("cl51_cd", clean_done, 1'b0);

        // Menu beats right on the same edge; menu aborts CLEAN silently.
        btns(1'b1, 1'b0, 1'b1);
        step(1);
        check_eq("prio_sel", selection, 8'h10);
        check_eq("prio_right", right_time, 8'd5);
        btns(1'b0, 1'b0, 1'b0);
        step(1);
        btns(1'b1, 1'b0, 1'b0);
        step(1);
        check_eq("abort_sel", selection, 8'h01);
        check_eq("abort_cd", clean_done, 1'b0);
        btns(1'b0, 1'b0, 1'b0);
        step(1);
        check_eq("abort_cd2", clean_done, 1'b0);

        // Left steps down; left beats right (and is ignored in standby).
        press_right("lt_up_sel", 8'h02);
        btns(1'b0, 1'b1, 1'b0);
        step(1);
        check_eq("lt_down_sel", selection, 8'h01);
        btns(1'b0, 1'b0, 1'b0);
        step(1);
        btns(1'b0, 1'b1, 1'b1);
        step(1);
        check_eq("lt_prio_sel", selection, 8'h01);
        btns(1'b0, 1'b0, 1'b0);
        step(1);

        // Reset mid-CLEAN.
        btns(1'b1, 1'b0, 1'b0);
        step(1);
        check_eq("rcl_sel", selection, 8'h10);
        btns(1'b0, 1'b0, 1'b0);
        step(5);
        rst = 1'b0;
        #1;
        check_eq("rcl_rst_sel", selection, 8'h00);
        check_eq("rcl_rst_left", left_time, 8'd0);
        check_eq("rcl_rst_right", right_time, 8'd0);
        check_eq("rcl_rst_cd", clean_done, 1'b0);
        step(60);
        check_eq("rcl_hold_sel", selection, 8'h00);
        check_eq("rcl_hold_cd", clean_done, 1'b0);
        rst = 1'b1;
        step(1);
        check_eq("rcl_rel_sel", selection, 8'h01);
        check_eq("rcl_rel_right", right_time, 8'd0);
        check_eq("rcl_rel_cd", clean_done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mode_timer_ctrl.md
MODE_TIMER_CTRL -- requirements
Module: mode_timer_ctrl

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 100_000_000, clk cycles per one-second tick.
REQ-002 The block SHALL have parameter LEVEL3_SEC, default 60, LEVEL3 run time in seconds (1..255).
REQ-003 The block SHALL have parameter CLEAN_SEC, default 180, CLEAN run time in seconds (1..255).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port power_status, input, 1, from the power on/off stage (1 = on).
REQ-008 The block SHALL have port menu_stable, input, 1, debounced menu button level.
REQ-009 The block SHALL have port left_stable, input, 1, debounced left button level.
REQ-010 The block SHALL have port right_stable, input, 1, debounced right button level.
REQ-011 The block SHALL have port selection, output, 8, one-hot current mode.
REQ-012 The block SHALL have port left_time, output, 8, elapsed seconds in current mode.
REQ-013 The block SHALL have port right_time, output, 8, remaining seconds of a timed mode.
REQ-014 The block SHALL have port clean_done, output, 1, one-cycle pulse on CLEAN completion.

Function
REQ-015 Outputs SHALL be registered; each button has a prev register; edge = stable & !prev, acted on at the same clock edge; response visible one cycle after the rising level is first sampled.
REQ-016 States and selection encoding SHALL be: OFF 0x00, STANDBY 0x01, LEVEL1 0x02, LEVEL2 0x04, LEVEL3 0x08, CLEAN 0x10.
REQ-017 power_status=0 SHALL force OFF on the next edge from any state, overriding all button edges, and clear left_time, right_time and the level3_used flag.
REQ-018 OFF with power_status=1 SHALL go to STANDBY; button edges in that same cycle SHALL be ignored.
REQ-019 Button edges SHALL have priority menu > left > right; only the highest-priority edge acts in a given cycle.
REQ-020 menu edge: STANDBY->CLEAN; CLEAN->STANDBY (abort, no clean_done); LEVEL1/2/3->STANDBY.
REQ-021 right edge: STANDBY->LEVEL1; LEVEL1->LEVEL2; LEVEL2->LEVEL3 only if level3_used=0, else ignored; ignored in LEVEL3 and CLEAN.
REQ-022 left edge: LEVEL1->STANDBY; LEVEL2->LEVEL1; LEVEL3->LEVEL2; ignored in STANDBY and CLEAN.
REQ-023 Entering LEVEL3 SHALL set level3_used=1 and load right_time=LEVEL3_SEC; entering CLEAN SHALL load right_time=CLEAN_SEC; all other states hold right_time=0.
REQ-024 A 1 s prescaler SHALL reset to 0 on every state change; tick asserted when count = TICKS_PER_SEC-1, so the first tick falls exactly TICKS_PER_SEC cycles after state entry.
REQ-025 On every state change left_time SHALL become 0; on each tick it SHALL increment, saturating at 255; it SHALL stay 0 in OFF.
REQ-026 In LEVEL3/CLEAN each tick SHALL decrement right_time; a tick with right_time=1 SHALL instead transition (LEVEL3->LEVEL2, CLEAN->STANDBY) with right_time=0.
REQ-027 clean_done SHALL pulse high for exactly one cycle, coincident with the CLEAN->STANDBY timeout transition only.
REQ-028 A button edge and a timeout tick in the same cycle SHALL resolve with the button edge taking effect and the timeout discarded.

Reset
REQ-029 rst=0 SHALL asynchronously force state OFF, selection=0x00, left_time=0, right_time=0, clean_done=0, prescaler=0, level3_used=0, all prev registers=0.
REQ-030 Reset mid-mode (e.g. during CLEAN) SHALL abort with no clean_done pulse; after release the block SHALL go to STANDBY on the first edge with power_status=1.

Verification (TICKS_PER_SEC=10, LEVEL3_SEC=3, CLEAN_SEC=5)
REQ-031 The bench SHALL cover: power_status 0->1 -> selection 0x01 next cycle; 25 cycles later left_time=2, right_time=0.
REQ-032 The bench SHALL cover: STANDBY, three right edges -> selection 0x02, 0x04, 0x08, right_time=3; after 30 cycles -> selection 0x04, right_time=0; a fourth right edge -> stays 0x04.
REQ-033 The bench SHALL cover: STANDBY, menu edge -> 0x10, right_time=5; 50 cycles later -> 0x01 with clean_done high exactly one cycle.
REQ-034 The bench SHALL cover: menu and right rising on the same cycle in STANDBY -> 0x10 (menu wins).
REQ-035 The bench SHALL cover: power_status 1->0 during LEVEL3 -> selection 0x00, times 0; power back on, right x3 -> reaches 0x08 again (level3_used cleared).
REQ-036 The bench SHALL cover: rst pulsed low mid-CLEAN -> all outputs 0 immediately, no clean_done.
